// File: rtl/ascon_perm_scheduler.sv
// Arbitrates the shared Ascon permutation core between the fetch keystream path and
// background patch precompute, sequencing LOAD / ROUND / DONE with fully registered controls.
module ascon_perm_scheduler #(
  parameter int PB_ROUNDS        = 6,
  parameter int HW_PERMUTATION_N = 2,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic       clk_ascon_fast_i,
  input  logic       rst_ni,
  input  logic       req_fetch_i,
  input  logic       req_patch_i,
  input  logic       abort_fetch_i,
  output logic       gnt_fetch_o,
  output logic       gnt_patch_o,
  output logic       perm_load_o,
  output logic       perm_src_o,
  output logic       perm_en_o,
  output logic [3:0] round_idx_o,
  output logic       done_fetch_o,
  output logic       done_patch_o,
  output logic       busy_o
);

  localparam logic [3:0] IDX_BASE   = 4'(12 - PB_ROUNDS);
  localparam logic [3:0] IDX_STEP   = 4'(HW_PERMUTATION_N);
  localparam logic [3:0] RND_LAST   = 4'(PB_ROUNDS / HW_PERMUTATION_N - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_PATCH = 1'b1
  } owner_e;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] starve_q, starve_d;

  logic       gnt_fetch_q, gnt_fetch_d;
  logic       gnt_patch_q, gnt_patch_d;
  logic       perm_load_q, perm_load_d;
  logic       perm_src_q, perm_src_d;
  logic       perm_en_q, perm_en_d;
  logic [3:0] round_idx_q, round_idx_d;
  logic       done_fetch_q, done_fetch_d;
  logic       done_patch_q, done_patch_d;
  logic       busy_q, busy_d;

  logic       patch_wins;
  logic       fetch_abort;

  // Patch takes the core when fetch is idle, or when fetch has starved it long enough.
  assign patch_wins  = req_patch_i && (!req_fetch_i || (starve_q == STARVE_MAX));
  assign fetch_abort = abort_fetch_i && (owner_q == OWN_FETCH) &&
                       ((state_q == S_LOAD) || (state_q == S_ROUND));

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rnd_d    = rnd_q;
    starve_d = starve_q;

    unique case (state_q)
      S_IDLE: begin
        rnd_d = '0;
        if (!req_patch_i) begin
          starve_d = '0;
        end
        if (patch_wins) begin
          owner_d  = OWN_PATCH;
          state_d  = S_LOAD;
          starve_d = '0;
        end else if (req_fetch_i) begin
          owner_d = OWN_FETCH;
          state_d = S_LOAD;
          if (req_patch_i && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      S_LOAD: begin
        state_d = S_ROUND;
        rnd_d   = '0;
      end
      S_ROUND: begin
        if (rnd_q == RND_LAST) begin
          state_d = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rnd_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect kills an in-flight fetch before it can report done.
    if (fetch_abort) begin
      state_d  = S_IDLE;
      rnd_d    = '0;
      starve_d = '0;
    end
  end

  // Outputs are decoded from next-state values so they can be flopped and still
  // line up with the state they describe.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    gnt_fetch_d  = busy_d && (owner_d == OWN_FETCH);
    gnt_patch_d  = busy_d && (owner_d == OWN_PATCH);
    perm_src_d   = gnt_patch_d;
    perm_load_d  = (state_d == S_LOAD);
    perm_en_d    = (state_d == S_ROUND);
    round_idx_d  = perm_en_d ? (IDX_BASE + rnd_d * IDX_STEP) : 4'd0;
    done_fetch_d = (state_d == S_DONE) && (owner_d == OWN_FETCH);
    done_patch_d = (state_d == S_DONE) && (owner_d == OWN_PATCH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_ascon_fast_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      rnd_q        <= '0;
      starve_q     <= '0;
      gnt_fetch_q  <= 1'b0;
      gnt_patch_q  <= 1'b0;
      perm_load_q  <= 1'b0;
      perm_src_q   <= 1'b0;
      perm_en_q    <= 1'b0;
      round_idx_q  <= '0;
      done_fetch_q <= 1'b0;
      done_patch_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rnd_q        <= rnd_d;
      starve_q     <= starve_d;
      gnt_fetch_q  <= gnt_fetch_d;
      gnt_patch_q  <= gnt_patch_d;
      perm_load_q  <= perm_load_d;
      perm_src_q   <= perm_src_d;
      perm_en_q    <= perm_en_d;
      round_idx_q  <= round_idx_d;
      done_fetch_q <= done_fetch_d;
      done_patch_q <= done_patch_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt_fetch_o  = gnt_fetch_q;
  assign gnt_patch_o  = gnt_patch_q;
  assign perm_load_o  = perm_load_q;
  assign perm_src_o   = perm_src_q;
  assign perm_en_o    = perm_en_q;
  assign round_idx_o  = round_idx_q;
  assign done_fetch_o = done_fetch_q;
  assign done_patch_o = done_patch_q;
  assign busy_o       = busy_q;

  a_param_multiple: assert property (@(posedge clk_ascon_fast_i)
    (PB_ROUNDS % HW_PERMUTATION_N) == 0);
  a_done_fetch_gnt: assert property (@(posedge clk_ascon_fast_i) disable iff (!rst_ni)
    done_fetch_o |-> gnt_fetch_o);
  a_done_patch_gnt: assert property (@(posedge clk_ascon_fast_i) disable iff (!rst_ni)
    done_patch_o |-> gnt_patch_o);
  a_en_in_round: assert property (@(posedge clk_ascon_fast_i) disable iff (!rst_ni)
    perm_en_o |-> (state_q == S_ROUND));

endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// Directed bench for ascon_perm_scheduler: default instance (NC=3) plus a
// PB_ROUNDS=12 / HW_PERMUTATION_N=3 instance for the index sweep.
module tb_ascon_perm_scheduler;

  logic       clk;
  logic       rst_n;
  logic       req_fetch, req_patch, abort_fetch;
  logic       gnt_fetch, gnt_patch, perm_load, perm_src, perm_en;
  logic [3:0] round_idx;
  logic       done_fetch, done_patch, busy;

  logic       req_fetch12;
  logic       gnt_fetch12, gnt_patch12, perm_load12, perm_src12, perm_en12;
  logic [3:0] round_idx12;
  logic       done_fetch12, done_patch12, busy12;

  int checks = 0;
  int errors = 0;

  ascon_perm_scheduler u_dut (
    .clk_ascon_fast_i (clk),
    .rst_ni           (rst_n),
    .req_fetch_i      (req_fetch),
    .req_patch_i      (req_patch),
    .abort_fetch_i    (abort_fetch),
    .gnt_fetch_o      (gnt_fetch),
    .gnt_patch_o      (gnt_patch),
    .perm_load_o      (perm_load),
    .perm_src_o       (perm_src),
    .perm_en_o        (perm_en),
    .round_idx_o      (round_idx),
    .done_fetch_o     (done_fetch),
    .done_patch_o     (done_patch),
    .busy_o           (busy)
  );

  ascon_perm_scheduler #(
    .PB_ROUNDS        (12),
    .HW_PERMUTATION_N (3),
    .STARVE_LIMIT     (4)
  ) u_dut12 (
    .clk_ascon_fast_i (clk),
    .rst_ni           (rst_n),
    .req_fetch_i      (req_fetch12),
    .req_patch_i      (1'b0),
    .abort_fetch_i    (1'b0),
    .gnt_fetch_o      (gnt_fetch12),
    .gnt_patch_o      (gnt_patch12),
    .perm_load_o      (perm_load12),
    .perm_src_o       (perm_src12),
    .perm_en_o        (perm_en12),
    .round_idx_o      (round_idx12),
    .done_fetch_o     (done_fetch12),
    .done_patch_o     (done_patch12),
    .busy_o           (busy12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the LOAD-cycle sample point; returns at the DONE-cycle sample point.
  // abort_k pulses abort_fetch on that ROUND cycle (-1 for none).
  task automatic run_op(input logic patch, input int abort_k, input string tag);
    check({tag, ":load"}, {gnt_fetch, gnt_patch, perm_load, perm_src, perm_en, busy},
          {~patch, patch, 1'b1, patch, 1'b0, 1'b1});
    for (int k = 0; k < 3; k++) begin
      tick();
      check({tag, ":round"}, {gnt_fetch, gnt_patch, perm_load, perm_src, perm_en},
            {~patch, patch, 1'b0, patch, 1'b1});
      check({tag, ":idx"}, {12'd0, round_idx}, 16'(6 + 2 * k));
      abort_fetch = (k == abort_k);
    end
    tick();
    abort_fetch = 1'b0;
    check({tag, ":done"}, {done_fetch, done_patch, perm_en, gnt_fetch, gnt_patch},
          {~patch, patch, 1'b0, ~patch, patch});
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":idle"}, {busy, gnt_fetch, gnt_patch, perm_src, done_fetch, done_patch},
          16'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_fetch   = 1'b0;
    req_patch   = 1'b0;
    abort_fetch = 1'b0;
    req_fetch12 = 1'b0;

    // Reset values
    tick();
    check("reset", {gnt_fetch, gnt_patch, perm_load, perm_src, perm_en, round_idx,
                    done_fetch, done_patch, busy}, 16'd0);
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Single fetch: request at cycle 0, LOAD at 1, rounds 6/8/10, done at 5, idle at 6
    req_fetch = 1'b1;
    tick();
    run_op(1'b0, -1, "single_fetch");
    req_fetch = 1'b0;
    tick();
    check_idle("single_fetch");

    // Simultaneous requests: fetch first, patch LOAD two cycles after done_fetch
    req_fetch = 1'b1;
    req_patch = 1'b1;
    tick();
    run_op(1'b0, -1, "simul_fetch");
    req_fetch = 1'b0;
    tick();
    check_idle("simul_gap");
    tick();
    run_op(1'b1, -1, "simul_patch");
    req_patch = 1'b0;
    tick();
    check_idle("simul_patch");

    // Starvation: four fetches, then a forced patch, then fetch resumes
    req_fetch = 1'b1;
    req_patch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      run_op(1'b0, -1, $sformatf("starve_fetch%0d", i));
      tick();
      check_idle("starve_gap");
    end
    tick();
    run_op(1'b1, -1, "starve_patch");
    req_patch = 1'b0;
    tick();
    check_idle("starve_patch");
    tick();
    run_op(1'b0, -1, "starve_resume");
    req_fetch = 1'b0;
    tick();
    check_idle("starve_resume");

    // Abort on the second ROUND cycle of a fetch, with patch pending
    req_fetch = 1'b1;
    req_patch = 1'b1;
    tick();
    check("abort:load", {gnt_fetch, perm_load}, {1'b1, 1'b1});
    tick();
    check("abort:r0", {12'd0, round_idx}, 16'd6);
    tick();
    check("abort:r1", {12'd0, round_idx}, 16'd8);
    abort_fetch = 1'b1;
    req_fetch   = 1'b0;
    tick();
    abort_fetch = 1'b0;
    check("abort:idle", {busy, perm_en, done_fetch, gnt_fetch}, 16'd0);
    tick();
    // Pending patch is granted; abort pulsed during it must be ignored
    run_op(1'b1, 1, "abort_during_patch");
    req_patch = 1'b0;
    tick();
    check_idle("abort_during_patch");

    // Asynchronous reset mid-ROUND, then a full restart with the request held
    req_fetch = 1'b1;
    tick();
    tick();
    check("rst_mid:round", {12'd0, perm_en, busy, 2'b0}, {12'd0, 1'b1, 1'b1, 2'b0});
    rst_n = 1'b0;
    #1;
    check("rst_mid:async", {gnt_fetch, gnt_patch, perm_load, perm_src, perm_en, round_idx,
                            done_fetch, done_patch, busy}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(1'b0, -1, "rst_restart");
    req_fetch = 1'b0;
    tick();
    check_idle("rst_restart");

    // PB_ROUNDS=12, HW_PERMUTATION_N=3: indices 0,3,6,9; done 6 cycles after request
    req_fetch12 = 1'b1;
    tick();
    check("p12:load", {gnt_fetch12, perm_load12, perm_en12}, {1'b1, 1'b1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      tick();
      check("p12:en", {perm_en12, done_fetch12}, {1'b1, 1'b0});
      check("p12:idx", {12'd0, round_idx12}, 16'(3 * k));
    end
    tick();
    check("p12:done", {done_fetch12, done_patch12, perm_en12, gnt_patch12, perm_src12},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    req_fetch12 = 1'b0;
    tick();
    check("p12:idle", {busy12, gnt_fetch12, done_fetch12}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_perm_scheduler.md
Name: ascon_perm_scheduler

Overview:
- Sequences the shared Ascon permutation core, which is unrolled HW_PERMUTATION_N rounds per cycle.
- Arbitrates the core between two requesters:
  - fetch-path keystream generation (latency-critical);
  - patch-state precompute (background).
- Drives load/enable/round-index controls to the permutation datapath and returns per-requester done pulses.
- Sits between the ascon FSM / patch logic and the permutation core, in the fast Ascon clock domain.

Parameters:
- PB_ROUNDS, 6, rounds per permutation; must be a multiple of HW_PERMUTATION_N, max 12.
- HW_PERMUTATION_N, 2, rounds computed per cycle by the core.
- STARVE_LIMIT, 4, consecutive fetch grants while patch waits before patch is forced; range 1..15.

Ports:
- clk_ascon_fast_i  input  1  clock (all state on rising edge).
- rst_ni  input  1  asynchronous active-low reset.
- req_fetch_i  input  1  fetch requester wants a permutation; level, held until done_fetch_o.
- req_patch_i  input  1  patch requester wants a permutation; level, held until done_patch_o.
- abort_fetch_i  input  1  control-flow redirection; cancels an in-flight fetch operation.
- gnt_fetch_o  output  1  fetch owns the core (LOAD through DONE).
- gnt_patch_o  output  1  patch owns the core (LOAD through DONE).
- perm_load_o  output  1  load the source state into the core this cycle.
- perm_src_o  output  1  state source select: 0 = fetch, 1 = patch; stable while granted.
- perm_en_o  output  1  core advances HW_PERMUTATION_N rounds this cycle.
- round_idx_o  output  4  round-constant index of the first round computed this cycle.
- done_fetch_o  output  1  one-cycle pulse: fetch result valid in core state.
- done_patch_o  output  1  one-cycle pulse: patch result valid in core state.
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- Reset: every output is 0; FSM = IDLE; round counter = 0; starvation counter = 0; owner = fetch.
- FSM states and transitions:
  - IDLE: arbitrate; if any request, latch owner and go to LOAD; else stay.
  - LOAD (1 cycle): perm_load_o=1; go to ROUND.
  - ROUND (NC = PB_ROUNDS/HW_PERMUTATION_N cycles): perm_en_o=1 and round_idx_o = (12-PB_ROUNDS) + k*HW_PERMUTATION_N, for k = 0..NC-1. Go to DONE after k = NC-1.
  - DONE (1 cycle): done pulse for the owner; go to IDLE.
- Every output is registered (Moore). Request seen in IDLE -> LOAD on the next cycle. First request cycle to done pulse = NC+2 cycles.
- Back-to-back: a new operation can reach LOAD earliest 2 cycles after DONE (DONE -> IDLE -> LOAD).
- Arbitration in IDLE:
  - fetch has priority over patch;
  - exception: if req_patch_i and starvation counter == STARVE_LIMIT, patch wins.
- Starvation counter:
  - increments on each fetch grant while req_patch_i=1;
  - clears on a patch grant or when req_patch_i=0 in IDLE;
  - saturates at STARVE_LIMIT.
- gnt_*_o and perm_src_o reflect the owner from LOAD through DONE and are 0 in IDLE; the owner cannot change mid-operation.
- Request deassertion mid-operation is ignored; the operation completes and done is still pulsed.
- abort_fetch_i:
  - In LOAD or ROUND with owner = fetch: next state IDLE, no done_fetch_o, counters cleared. Abort takes priority over all other transitions.
  - In DONE with owner = fetch: the done pulse still fires.
  - While patch owns the core, or in IDLE: no effect.
- Abort and new request in the same cycle: the abort cycle returns to IDLE; arbitration happens in the following IDLE cycle.
- done_fetch_o and done_patch_o are never asserted together; gnt_fetch_o and gnt_patch_o are mutually exclusive.
- Round counter width: ceil(log2(12)) = 4 bits. Index arithmetic is modulo 16, but legal parameters never exceed 11.
- Asynchronous reset mid-operation: immediate return to reset values, no done pulse.
- Assertions, simulation only:
  - PB_ROUNDS % HW_PERMUTATION_N == 0;
  - no done pulse without a grant;
  - perm_en_o only in ROUND.

Test Plan:
- Single fetch (defaults, NC=3): req_fetch_i high at cycle 0 -> gnt_fetch_o high from cycle 1; perm_load_o at 1; perm_en_o at 2-4 with round_idx_o 6, 8, 10; done_fetch_o at 5; busy_o low at 6.
- Simultaneous req_fetch_i and req_patch_i from IDLE -> fetch served first. Patch LOAD occurs 2 cycles after done_fetch_o with perm_src_o=1; done_patch_o at NC+2 cycles after that.
- Starvation: req_fetch_i held continuously, req_patch_i held, STARVE_LIMIT=4 -> 4 fetch operations, then one patch operation, then fetch resumes.
- Abort: abort_fetch_i pulsed on the 2nd ROUND cycle of a fetch -> IDLE next cycle; no done_fetch_o; a pending patch is granted on the following cycle.
- Abort during patch ownership -> ignored; done_patch_o fires on schedule with round_idx_o sequence 6, 8, 10.
- Reset asserted mid-ROUND -> all outputs 0 immediately. After release with req_fetch_i held, the full NC+2 sequence restarts from LOAD.
- Parameter sweep PB_ROUNDS=12, HW_PERMUTATION_N=3 -> round_idx_o 0, 3, 6, 9; done_fetch_o 6 cycles after the request cycle.
